delay_line_ctrl: RTL

- Controller for the 16-bit sample delay line, memory-based form: sequences a circular buffer in an external simple-dual-port RAM (1-cycle read latency) to give a runtime-programmable delay of 1..DEPTH-1 samples.
- Replaces fixed-length register chains where delay must change in operation.
- Handles priming (fill), delay reconfiguration (flush/refill), and the input/output valid handshake.
- Sits between the sample source and downstream filter/processing logic.

---
 rtl/delay_line_if.sv | 32 +++
 rtl/delay_line_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/delay_line_if.sv
// Sample stream and RAM port bundle for the memory-based delay line.
// master = controller side, slave = sample source / RAM / consumer side.
interface delay_line_if #(
   parameter int AW       = 13,
   parameter int BUS_SIZE = 16
) ();
   logic                in_valid;
   logic [BUS_SIZE-1:0] in_data;
   logic                in_ready;

   logic                ram_we;
   logic [AW-1:0]       ram_waddr;
   logic [BUS_SIZE-1:0] ram_wdata;
   logic                ram_re;
   logic [AW-1:0]       ram_raddr;
   logic [BUS_SIZE-1:0] ram_rdata;

   logic                out_valid;
   logic [BUS_SIZE-1:0] out_data;

   modport master (
      input  in_valid, in_data, ram_rdata,
      output in_ready, ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
             out_valid, out_data
   );

   modport slave (
      output in_valid, in_data, ram_rdata,
      input  in_ready, ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
             out_valid, out_data
   );
endinterface

// File: rtl/delay_line_ctrl.sv
// Circular-buffer sequencer for a runtime-programmable sample delay held in an
// external simple-dual-port RAM with one cycle of read latency. The delay is
// counted in accepted samples; every reconfiguration or re-enable refills the
// buffer so stale RAM contents never reach the output.
module delay_line_ctrl #(
   parameter int DEPTH         = 5000,
   parameter int AW            = 13,
   parameter int BUS_SIZE      = 16,
   parameter int DEFAULT_DELAY = 4999
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable,
   input  logic          cfg_load,
   input  logic [AW-1:0] delay_cfg,
   output logic          cfg_err,
   output logic          primed,
   output logic [AW-1:0] delay_cur,
   delay_line_if.master  bus
);

   typedef enum logic [1:0] {IDLE, FLUSH, FILL, RUN} state_t;

   localparam logic [AW:0]         DEPTH_X = (AW+1)'(DEPTH);
   localparam logic [AW:0]         MAX_X   = (AW+1)'(DEPTH-1);
   localparam logic [AW-1:0]       LAST    = AW'(DEPTH-1);
   localparam logic [AW-1:0]       ONE     = AW'(1);
   localparam logic [AW-1:0]       DLY_RST = AW'(DEFAULT_DELAY);
   localparam logic [BUS_SIZE-1:0] ZERO_D  = '0;

   state_t        state, state_nxt;
   logic [AW-1:0] wp, wp_nxt;
   logic [AW-1:0] fill_cnt, fill_cnt_nxt;
   logic [AW-1:0] delay_nxt;
   logic          cfg_err_nxt;
   logic          accept_p0;
   logic          rd_p0;
   logic          vld_p1;

   // Read address = (wp - delay) mod DEPTH, one extra bit so the wrap add never overflows.
   function automatic logic [AW-1:0] rd_addr(input logic [AW-1:0] w, input logic [AW-1:0] d);
      logic [AW:0] w_x, d_x, r_x;
      w_x = {1'b0, w};
      d_x = {1'b0, d};
      if (w_x >= d_x) r_x = w_x - d_x;
      else            r_x = w_x + DEPTH_X - d_x;
      return r_x[AW-1:0];
   endfunction

   // Write pointer advance, wrapping at the last RAM word rather than at 2^AW.
   function automatic logic [AW-1:0] wp_inc(input logic [AW-1:0] w);
      return (w == LAST) ? '0 : w + ONE;
   endfunction

   // A delay of zero or one that reaches the write slot is unusable.
   function automatic logic cfg_ok(input logic [AW-1:0] d);
      return (d != '0) && ({1'b0, d} <= MAX_X);
   endfunction

   // p0: sample acceptance, RAM write and (in RUN) the delayed read issue
   assign bus.in_ready  = enable & ((state == FILL) | (state == RUN)) & ~cfg_load;
   assign accept_p0     = bus.in_valid & bus.in_ready;
   assign rd_p0         = accept_p0 & (state == RUN);
   assign bus.ram_we    = accept_p0;
   assign bus.ram_waddr = wp;
   assign bus.ram_wdata = accept_p0 ? bus.in_data : ZERO_D;
   assign bus.ram_re    = rd_p0;
   assign bus.ram_raddr = rd_p0 ? rd_addr(wp, delay_cur) : '0;

   // p1: RAM read data returns alongside its valid
   assign bus.out_valid = vld_p1;
   assign bus.out_data  = vld_p1 ? bus.ram_rdata : ZERO_D;
   assign primed        = (state == RUN);

   // Next-state and pointer logic: enable-low beats cfg_load, which beats sample transfer.
   always_comb begin
      state_nxt    = state;
      wp_nxt       = wp;
      fill_cnt_nxt = fill_cnt;
      delay_nxt    = delay_cur;
      cfg_err_nxt  = 1'b0;
      if (state == IDLE) begin
         if (cfg_load) begin
            if (cfg_ok(delay_cfg)) delay_nxt   = delay_cfg;
            else                   cfg_err_nxt = 1'b1;
         end else if (enable) begin
            state_nxt = FLUSH;
         end
      end else if (!enable) begin
         state_nxt = IDLE;
      end else if (cfg_load) begin
         if (cfg_ok(delay_cfg)) begin
            delay_nxt = delay_cfg;
            state_nxt = FLUSH;
         end else begin
            cfg_err_nxt = 1'b1;
         end
      end else begin
         case (state)
            FLUSH: begin
               wp_nxt       = '0;
               fill_cnt_nxt = '0;
               state_nxt    = FILL;
            end
            FILL: begin
               if (accept_p0) begin
                  wp_nxt       = wp_inc(wp);
                  fill_cnt_nxt = fill_cnt + ONE;
                  if (fill_cnt + ONE == delay_cur) state_nxt = RUN;
               end
            end
            RUN: begin
               if (accept_p0) wp_nxt = wp_inc(wp);
            end
            default: ;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Pointer, fill count, active delay, error pulse and output-valid registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wp        <= '0;
         fill_cnt  <= '0;
         delay_cur <= DLY_RST;
         cfg_err   <= 1'b0;
         vld_p1    <= 1'b0;
      end else begin
         wp        <= wp_nxt;
         fill_cnt  <= fill_cnt_nxt;
         delay_cur <= delay_nxt;
         cfg_err   <= cfg_err_nxt;
         vld_p1    <= rd_p0;
      end
   end

endmodule
